// File: rtl/vga_timing_gen_pkg.sv
// Shared timing defaults, widths and axis state encoding for the VGA raster generator.
package vga_timing_gen_pkg;

    // 640x480@60 defaults
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FRONT_DEF  = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BACK_DEF   = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FRONT_DEF  = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BACK_DEF   = 33;

    localparam int unsigned POS_W   = 10;
    localparam int unsigned Y_W     = 9;
    localparam int unsigned FRAME_W = 10;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } axis_state_e;

    // Phase order along one axis
    function automatic axis_state_e next_phase(input axis_state_e s);
        axis_state_e n;
        n = ST_ACTIVE;
        case (s)
            ST_ACTIVE: n = ST_FRONT;
            ST_FRONT:  n = ST_SYNC;
            ST_SYNC:   n = ST_BACK;
            ST_BACK:   n = ST_ACTIVE;
            default:   n = ST_ACTIVE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_fsm.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Ports: clk, rst_n, step (advance one unit); pos (current position),
//        in_active/in_sync (current phase decode), wrap (last unit of the axis).
module vga_axis_fsm
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned FRONT  = H_FRONT_DEF,
    parameter int unsigned SYNC   = H_SYNC_DEF,
    parameter int unsigned BACK   = H_BACK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [POS_W-1:0] pos,
    output logic             in_active,
    output logic             in_sync,
    output logic             wrap
);

    localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;

    axis_state_e      state, state_nxt;
    logic [POS_W-1:0] phase_cnt, phase_nxt;
    logic [POS_W-1:0] pos_nxt;

    // Reload value (length - 1) for the phase being entered
    function automatic logic [POS_W-1:0] phase_last(input axis_state_e s);
        logic [POS_W-1:0] r;
        r = POS_W'(ACTIVE - 1);
        case (s)
            ST_ACTIVE: r = POS_W'(ACTIVE - 1);
            ST_FRONT:  r = POS_W'(FRONT - 1);
            ST_SYNC:   r = POS_W'(SYNC - 1);
            ST_BACK:   r = POS_W'(BACK - 1);
            default:   r = POS_W'(ACTIVE - 1);
        endcase
        return r;
    endfunction

    // State, phase and position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACTIVE;
            phase_cnt <= POS_W'(ACTIVE - 1);
            pos       <= '0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            pos       <= pos_nxt;
        end
    end

    // Next state: phase counter counts down, state moves on the last unit of a phase
    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
        pos_nxt   = pos;
        if (step) begin
            pos_nxt = (pos == POS_W'(TOTAL - 1)) ? '0 : pos + POS_W'(1);
            if (phase_cnt == '0) begin
                state_nxt = next_phase(state);
                phase_nxt = phase_last(next_phase(state));
            end else begin
                phase_nxt = phase_cnt - POS_W'(1);
            end
        end
    end

    assign in_active = (state == ST_ACTIVE);
    assign in_sync   = (state == ST_SYNC);
    // Last unit of BACK is the last position of the axis
    assign wrap      = (state == ST_BACK) && (phase_cnt == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: registered x/y, frame_active, syncs, line/frame strobes
// and a free-running frame counter. Advances one pixel per pix_en.
// Ports: clk, rst_n, pix_en in; x, y, frame_active, h_sync, v_sync,
//        line_start, frame_start, frame_ctr out (all registered).
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FRONT  = H_FRONT_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BACK   = H_BACK_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FRONT  = V_FRONT_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BACK   = V_BACK_DEF,
    parameter bit          SYNC_NEG = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    output logic [POS_W-1:0]   x,
    output logic [Y_W-1:0]     y,
    output logic               frame_active,
    output logic               h_sync,
    output logic               v_sync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_ctr
);

    logic [POS_W-1:0] h_pos, v_pos;
    logic             h_in_active, h_in_sync, h_wrap;
    logic             v_in_active, v_in_sync, v_wrap_unused;
    logic             v_step;

    // Vertical axis advances on the horizontal wrap pixel
    assign v_step = pix_en & h_wrap;

    vga_axis_fsm #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (pix_en),
        .pos       (h_pos),
        .in_active (h_in_active),
        .in_sync   (h_in_sync),
        .wrap      (h_wrap)
    );

    vga_axis_fsm #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (v_step),
        .pos       (v_pos),
        .in_active (v_in_active),
        .in_sync   (v_in_sync),
        .wrap      (v_wrap_unused)
    );

    // Output registers load the decode of the current position; strobes self-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x            <= '0;
            y            <= '0;
            frame_active <= 1'b0;
            h_sync       <= SYNC_NEG;
            v_sync       <= SYNC_NEG;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            frame_ctr    <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                x            <= h_pos;
                y            <= v_pos[Y_W-1:0];
                frame_active <= h_in_active & v_in_active;
                h_sync       <= h_in_sync ^ SYNC_NEG;
                v_sync       <= v_in_sync ^ SYNC_NEG;
                line_start   <= (h_pos == '0);
                frame_start  <= (h_pos == '0) && (v_pos == '0);
                if ((h_pos == '0) && (v_pos == '0)) begin
                    frame_ctr <= frame_ctr + FRAME_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level timing and reset,
// small 7x6 instance for frame-level timing, FSM phases and frame counter wrap.
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pen_d = 1'b0;
    logic       pen_s = 1'b0;

    logic [9:0] d_x, s_x;
    logic [8:0] d_y, s_y;
    logic       d_fa, d_hs, d_vs, d_ls, d_fs;
    logic       s_fa, s_hs, s_vs, s_ls, s_fs;
    logic [9:0] d_fc, s_fc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_n), .pix_en(pen_d),
        .x(d_x), .y(d_y), .frame_active(d_fa), .h_sync(d_hs), .v_sync(d_vs),
        .line_start(d_ls), .frame_start(d_fs), .frame_ctr(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_NEG(1'b1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .pix_en(pen_s),
        .x(s_x), .y(s_y), .frame_active(s_fa), .h_sync(s_hs), .v_sync(s_vs),
        .line_start(s_ls), .frame_start(s_fs), .frame_ctr(s_fc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [9:0] px, input logic [8:0] py,
                                         input logic fa, input logic hs, input logic vs,
                                         input logic ls, input logic fs, input logic [9:0] fc);
        return 64'({px, py, fa, hs, vs, ls, fs, fc});
    endfunction

    function automatic logic [1:0] h_state_of(input int p);
        if (p < 4) return ST_ACTIVE;
        if (p == 4) return ST_FRONT;
        if (p == 5) return ST_SYNC;
        return ST_BACK;
    endfunction

    function automatic logic [1:0] v_state_of(input int p);
        if (p < 3) return ST_ACTIVE;
        if (p == 3) return ST_FRONT;
        if (p == 4) return ST_SYNC;
        return ST_BACK;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int xe, ye;

        // Reset state
        #2 rst_n = 1'b0;
        #2;
        chk("reset_d", pack(d_x, d_y, d_fa, d_hs, d_vs, d_ls, d_fs, d_fc),
            pack(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0));
        chk("reset_s", pack(s_x, s_y, s_fa, s_hs, s_vs, s_ls, s_fs, s_fc),
            pack(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0));
        @(negedge clk);
        rst_n = 1'b1;
        pen_d = 1'b1;

        // Two full lines with continuous pix_en, every pixel checked
        for (int i = 0; i < 1600; i++) begin
            tick();
            xe = i % 800;
            ye = i / 800;
            chk("line_scan", pack(d_x, d_y, d_fa, d_hs, d_vs, d_ls, d_fs, d_fc),
                pack(10'(xe), 9'(ye), xe < 640, !(xe >= 656 && xe <= 751), 1'b1,
                     xe == 0, i == 0, 10'd1));
        end

        // pix_en toggling: x advances every 2 clks, strobe one clk wide
        for (int k = 0; k < 10; k++) begin
            pen_d = (k % 2 == 0);
            tick();
            chk("toggle_x", 64'(d_x), 64'(k / 2));
            chk("toggle_ls", 64'(d_ls), 64'(k == 0));
        end

        // Advance to x=300 on line 2, then reset asynchronously mid-line
        pen_d = 1'b1;
        for (int i = 5; i <= 300; i++) tick();
        chk("pre_reset_pos", 64'({d_x, d_y}), 64'({10'd300, 9'd2}));
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset", pack(d_x, d_y, d_fa, d_hs, d_vs, d_ls, d_fs, d_fc),
            pack(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("restart", pack(d_x, d_y, d_fa, d_hs, d_vs, d_ls, d_fs, d_fc),
            pack(10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd1));
        pen_d = 1'b0;

        // Small 7x6 frame: outputs and both axis FSM states every pixel
        pen_s = 1'b1;
        for (int i = 0; i < 42; i++) begin
            tick();
            xe = i % 7;
            ye = i / 7;
            chk("small_frame", pack(s_x, s_y, s_fa, s_hs, s_vs, s_ls, s_fs, s_fc),
                pack(10'(xe), 9'(ye), (xe < 4) && (ye < 3), xe != 5, ye != 4,
                     xe == 0, i == 0, 10'd1));
            chk("h_state", 64'(dut_s.u_h_axis.state), 64'(h_state_of((i + 1) % 7)));
            chk("v_state", 64'(dut_s.u_v_axis.state), 64'(v_state_of(((i + 1) / 7) % 6)));
        end

        // Run to the 1023rd frame start, then across the counter wrap
        for (int k = 42; k <= 42 * 1022; k++) tick();
        chk("fc_1023_start", 64'({s_fc, s_fs, s_x, s_y}), 64'({10'd1023, 1'b1, 10'd0, 9'd0}));
        for (int k = 0; k < 41; k++) tick();
        chk("fc_1023_end", 64'({s_fc, s_fs, s_x, s_y}), 64'({10'd1023, 1'b0, 10'd6, 9'd5}));
        tick();
        chk("fc_wrap", 64'({s_fc, s_fs, s_x, s_y}), 64'({10'd0, 1'b1, 10'd0, 9'd0}));

        // Strobes clear after one clk even with pix_en low; position holds
        pen_s = 1'b0;
        tick();
        chk("strobe_clear", 64'({s_fs, s_ls, s_fa, s_x, s_fc}), 64'({1'b0, 1'b0, 1'b1, 10'd0, 10'd0}));
        tick();
        chk("hold", 64'({s_fs, s_ls, s_x, s_y}), 64'({1'b0, 1'b0, 10'd0, 9'd0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
